// File: rtl/focus_sweep_ctrl_if.sv
// focus_sweep_ctrl_if: the bundle of video, ROI/threshold control and VCM
// handshake signals that the autofocus engine uses.
// slave  = the focus engine's view
// master = the video source / VCM writer / host view
interface focus_sweep_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int VCM_W  = 10,
    parameter int ACC_W  = 32
);
    logic              VIDEO_VS;
    logic              VIDEO_HS;
    logic              VIDEO_DE;
    logic [DATA_W-1:0] iR;
    logic [DATA_W-1:0] iG;
    logic [DATA_W-1:0] iB;
    logic              START;
    logic [11:0]       ROI_X0;
    logic [11:0]       ROI_X1;
    logic [11:0]       ROI_Y0;
    logic [11:0]       ROI_Y1;
    logic [DATA_W-1:0] THRESH;
    logic [VCM_W-1:0]  VCM_DATA;
    logic              VCM_WR;
    logic              VCM_ACK;
    logic [ACC_W-1:0]  SHARP;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] oR;
    logic [DATA_W-1:0] oG;
    logic [DATA_W-1:0] oB;

    modport master (
        output VIDEO_VS, VIDEO_HS, VIDEO_DE, iR, iG, iB, START,
               ROI_X0, ROI_X1, ROI_Y0, ROI_Y1, THRESH, VCM_ACK,
        input  VCM_DATA, VCM_WR, SHARP, BUSY, DONE, oR, oG, oB
    );

    modport slave (
        input  VIDEO_VS, VIDEO_HS, VIDEO_DE, iR, iG, iB, START,
               ROI_X0, ROI_X1, ROI_Y0, ROI_Y1, THRESH, VCM_ACK,
        output VCM_DATA, VCM_WR, SHARP, BUSY, DONE, oR, oG, oB
    );
endinterface

// File: rtl/focus_sweep_ctrl.sv
// focus_sweep_ctrl: per-frame sharpness measurement (thresholded horizontal
// luma gradient energy inside an ROI) plus a coarse/fine VCM sweep that
// leaves the lens at the sharpest position found.
// Optional feature macro: FOCUS_OVERLAY_EN (yellow ROI border while BUSY).
module focus_sweep_ctrl #(
    parameter int DATA_W        = 8,
    parameter int VCM_W         = 10,
    parameter int ACC_W         = 32,
    parameter int STEP_COARSE   = 64,
    parameter int STEP_FINE     = 8,
    parameter int SETTLE_FRAMES = 2
) (
    input logic                VIDEO_CLK,
    input logic                RESET_N,
    focus_sweep_ctrl_if.slave  io_bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MOVE    = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_DECIDE  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam int SET_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam logic [VCM_W:0]   C_STEP_C = (VCM_W+1)'(STEP_COARSE);
    localparam logic [VCM_W:0]   C_STEP_F = (VCM_W+1)'(STEP_FINE);
    localparam logic [VCM_W-1:0] C_TOP    = '1;

    // video timing / coordinate tracking
    logic              r_vs_q, r_de_q;
    logic [11:0]       r_col, r_row;
    logic              w_vs_fall, w_de_fall, w_in_roi, w_grad_en;
    logic [11:0]       w_row_pix;
    logic [DATA_W+1:0] w_luma_sum;
    logic [DATA_W-1:0] w_luma;

    // gradient pipeline
    logic [DATA_W-1:0] r_y1, r_y0;
    logic              r_v1, r_b1;
    logic [DATA_W-1:0] w_diff, w_add;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  r_acc, r_sharp;

    // sweep control
    logic [2:0]        r_state;
    logic [VCM_W-1:0]  r_pos, r_best_pos, r_pass_end, r_vcm_data;
    logic [ACC_W-1:0]  r_best;
    logic              r_pass_fine, r_final, r_wr, r_busy, r_done;
    logic [SET_W-1:0]  r_settle;
    logic              w_better, w_more;
    logic [VCM_W-1:0]  w_nbest_pos, w_lo;
    logic [VCM_W:0]    w_step, w_next, w_hi_full;
    logic [VCM_W-1:0]  w_hi;

    // A boundary forces the current pixel onto row 0 of the new frame.
    always_comb begin
        w_vs_fall  = r_vs_q & ~io_bus.VIDEO_VS;
        w_de_fall  = r_de_q & ~io_bus.VIDEO_DE;
        w_row_pix  = w_vs_fall ? '0 : r_row;
        w_in_roi   = io_bus.VIDEO_DE &&
                     (r_col >= io_bus.ROI_X0) && (r_col <= io_bus.ROI_X1) &&
                     (w_row_pix >= io_bus.ROI_Y0) && (w_row_pix <= io_bus.ROI_Y1);
        w_grad_en  = w_in_roi && (r_col != io_bus.ROI_X0);
        w_luma_sum = {2'b00, io_bus.iR} + {1'b0, io_bus.iG, 1'b0} + {2'b00, io_bus.iB};
        w_luma     = DATA_W'(w_luma_sum >> 2);
    end

    // Column/row counters and sync edge history.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vs_q <= 1'b0;
            r_de_q <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
        end else begin
            r_vs_q <= io_bus.VIDEO_VS;
            r_de_q <= io_bus.VIDEO_DE;
            r_col  <= io_bus.VIDEO_DE ? r_col + 12'd1 : '0;
            if (w_vs_fall)
                r_row <= '0;
            else if (w_de_fall)
                r_row <= r_row + 12'd1;
        end
    end

    // Stage 1: register luma, gradient-valid flag and the aligned boundary.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_y1 <= '0;
            r_y0 <= '0;
            r_v1 <= 1'b0;
            r_b1 <= 1'b0;
        end else begin
            r_y1 <= w_luma;
            r_y0 <= r_y1;
            r_v1 <= w_grad_en;
            r_b1 <= w_vs_fall;
        end
    end

    always_comb begin
        w_diff = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
        w_add  = (r_v1 && (w_diff >= io_bus.THRESH)) ? w_diff : '0;
        w_sum  = {1'b0, r_acc} + (ACC_W+1)'(w_add);
    end

    // Stage 2: saturating accumulate. The boundary is carried with the pixel
    // so a pixel sampled on the VS edge lands in the new frame's total.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_acc   <= '0;
            r_sharp <= '0;
        end else if (r_b1) begin
            r_sharp <= r_acc;
            r_acc   <= ACC_W'(w_add);
        end else begin
            r_acc   <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
        end
    end

    // Next-position arithmetic used by DECIDE.
    always_comb begin
        w_better    = r_sharp > r_best;
        w_nbest_pos = w_better ? r_pos : r_best_pos;
        w_step      = r_pass_fine ? C_STEP_F : C_STEP_C;
        w_next      = {1'b0, r_pos} + w_step;
        w_more      = w_next <= {1'b0, r_pass_end};
        w_lo        = ({1'b0, w_nbest_pos} >= C_STEP_C) ?
                      (w_nbest_pos - C_STEP_C[VCM_W-1:0]) : '0;
        w_hi_full   = {1'b0, w_nbest_pos} + C_STEP_C;
        w_hi        = (w_hi_full > {1'b0, C_TOP}) ? C_TOP : w_hi_full[VCM_W-1:0];
    end

    // Sweep FSM: move lens, wait for settle frames, measure, decide.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_pos       <= '0;
            r_best      <= '0;
            r_best_pos  <= '0;
            r_pass_end  <= '0;
            r_pass_fine <= 1'b0;
            r_final     <= 1'b0;
            r_settle    <= '0;
            r_wr        <= 1'b0;
            r_vcm_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (io_bus.START) begin
                        r_pass_fine <= 1'b0;
                        r_pos       <= '0;
                        r_best      <= '0;
                        r_best_pos  <= '0;
                        r_pass_end  <= C_TOP;
                        r_final     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_state     <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (!r_wr) begin
                        r_wr       <= 1'b1;
                        r_vcm_data <= r_pos;
                    end else if (io_bus.VCM_ACK) begin
                        r_wr <= 1'b0;
                        if (r_final) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_settle <= '0;
                            r_state  <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_b1) begin
                        if (r_settle == SET_W'(SETTLE_FRAMES - 1))
                            r_state <= ST_MEASURE;
                        else
                            r_settle <= r_settle + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (r_b1)
                        r_state <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (w_better) begin
                        r_best     <= r_sharp;
                        r_best_pos <= r_pos;
                    end
                    if (w_more) begin
                        r_pos <= w_next[VCM_W-1:0];
                    end else if (!r_pass_fine) begin
                        r_pass_fine <= 1'b1;
                        r_pos       <= w_lo;
                        r_pass_end  <= w_hi;
                    end else begin
                        r_pos   <= w_nbest_pos;
                        r_final <= 1'b1;
                    end
                    r_state <= ST_MOVE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FOCUS_OVERLAY_EN
    logic w_border;
    always_comb begin
        w_border = r_busy && w_in_roi &&
                   ((r_col == io_bus.ROI_X0) || (r_col == io_bus.ROI_X1) ||
                    (w_row_pix == io_bus.ROI_Y0) || (w_row_pix == io_bus.ROI_Y1));
    end

    // Registered video out with yellow ROI border while sweeping.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            io_bus.oR <= '0;
            io_bus.oG <= '0;
            io_bus.oB <= '0;
        end else if (w_border) begin
            io_bus.oR <= '1;
            io_bus.oG <= '1;
            io_bus.oB <= '0;
        end else begin
            io_bus.oR <= io_bus.iR;
            io_bus.oG <= io_bus.iG;
            io_bus.oB <= io_bus.iB;
        end
    end
`else
    // Registered video pass-through.
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            io_bus.oR <= '0;
            io_bus.oG <= '0;
            io_bus.oB <= '0;
        end else begin
            io_bus.oR <= io_bus.iR;
            io_bus.oG <= io_bus.iG;
            io_bus.oB <= io_bus.iB;
        end
    end
`endif

    assign io_bus.VCM_DATA = r_vcm_data;
    assign io_bus.VCM_WR   = r_wr;
    assign io_bus.SHARP    = r_sharp;
    assign io_bus.BUSY     = r_busy;
    assign io_bus.DONE     = r_done;

endmodule

// File: doc/focus_sweep_ctrl.md
# focus_sweep_ctrl

Parametrised autofocus engine for the D8M video path. Measures a per-frame sharpness figure (thresholded horizontal luma gradient energy inside a programmable region of interest) and drives the camera VCM through a two-pass coarse/fine sweep, handing each lens position to the I2C VCM writer over a write/ack handshake. It sits between the sync-normalised video stream and the VCM I2C master. It replaces the fixed-window, single-mode focus path with configurable widths, step sizes, settle time and ROI.

## Interface
- DATA_W, 8: pixel component width.
- VCM_W, 10: VCM position width; range 0 .. 2^VCM_W-1.
- ACC_W, 32: sharpness accumulator width (saturating).
- STEP_COARSE, 64: coarse sweep step, in VCM codes.
- STEP_FINE, 8: fine sweep step; must be ≤ STEP_COARSE.
- SETTLE_FRAMES, 2: frames discarded after each lens move (≥1).
- VIDEO_CLK  in  1  pixel clock; the only clock.
- RESET_N  in  1  asynchronous, active-low reset.
- VIDEO_VS, VIDEO_HS  in  1  active-low sync pulses (already normalised).
- VIDEO_DE  in  1  active-pixel enable.
- iR, iG, iB  in  DATA_W  pixel components.
- START  in  1  single-cycle request; begins a sweep from IDLE or DONE.
- ROI_X0, ROI_X1, ROI_Y0, ROI_Y1  in  12  inclusive ROI bounds in active-pixel coordinates.
- THRESH  in  DATA_W  minimum gradient magnitude counted.
- VCM_DATA  out  VCM_W  requested lens position.
- VCM_WR  out  1  write request to the I2C writer.
- VCM_ACK  in  1  single-cycle pulse from the writer: write done.
- SHARP  out  ACC_W  metric of the last measured frame.
- BUSY, DONE  out  1  sweep in progress / sweep finished, lens at best.
- oR, oG, oB  out  DATA_W  video out (overlay, see Configuration).

## Operation
- Luma: Y = (R + 2G + B) >> 2, computed at DATA_W+2 bits and truncated to DATA_W.
- Column counter: increments on each DE cycle and clears when DE is low. Row counter: increments on each DE falling edge and clears on the VS falling edge.
- Gradient: g = |Y - Y_prev| for ROI pixels, excluding the first ROI pixel of each line. If g ≥ THRESH, add g to the accumulator, saturating at 2^ACC_W-1.
- Frame boundary: VS falling edge. At the boundary, SHARP <= accumulator and the accumulator clears.
- FSM states: IDLE, MOVE, SETTLE, MEASURE, DECIDE, DONE.
- IDLE/DONE + START → pass = coarse, pos = 0, best = 0, best_pos = 0, then MOVE.
- MOVE: VCM_DATA = pos, VCM_WR = 1. On VCM_ACK → SETTLE.
- SETTLE: count SETTLE_FRAMES frame boundaries → MEASURE.
- MEASURE: the next complete frame is measured. At its closing boundary → DECIDE.
- DECIDE: if SHARP > best (strict; ties keep the earlier position), update best and best_pos.
  - If pos + step ≤ pass_end, set pos += step and go to MOVE.
  - Otherwise, if pass = coarse: pass = fine, pos = max(best_pos - STEP_COARSE, 0), pass_end = min(best_pos + STEP_COARSE, 2^VCM_W-1), best is kept, then MOVE.
  - Otherwise (fine pass finished): pos = best_pos, final MOVE, then DONE.
- Coarse pass: pass_end = 2^VCM_W-1 and step = STEP_COARSE. Fine pass: step = STEP_FINE.
- START while BUSY is ignored.
- Reset values: VCM_DATA = 0, VCM_WR = 0, SHARP = 0, BUSY = 0, DONE = 0, o* = 0, FSM = IDLE, all counters 0.
- Reset mid-sweep aborts immediately. No write is issued after reset until the next START.

## Timing
- Luma/gradient pipeline: 2 cycles. o* lag i* by 1 cycle.
- SHARP updates 1 cycle after the sampled VS falling edge.
- VCM_WR rises 1 cycle after entering MOVE and falls the cycle after VCM_ACK is sampled.
- VCM_DATA is stable while VCM_WR = 1.
- VCM_ACK outside MOVE is ignored.
- A frame boundary during MOVE does not count toward SETTLE.
- BUSY is high from the cycle after START through the final ACK. DONE rises together with BUSY falling and clears on START.
- DE asserted across a VS edge: the boundary takes precedence, and that pixel goes to the new frame.

## Configuration
- FOCUS_OVERLAY_EN defined: o* = (DATA_W ones, DATA_W ones, 0), i.e. yellow, on ROI border pixels while BUSY. Otherwise o* = i*.
- FOCUS_OVERLAY_EN undefined: o* = i* always, registered, same 1-cycle latency. ROI compare logic for the overlay is omitted.

## Test plan
- Synthetic frame (64×8 active pixels) of alternating Y 0/100 columns, ROI (0..63, 0..7), THRESH = 50 → SHARP = 63 × 100 × 8 = 50400.
- Same frame with THRESH = 101 → SHARP = 0. With ACC_W = 16 and 2 such frames' content in one frame → SHARP saturates at 65535.
- Model: sharpness peaked at VCM 300, VCM_W = 10, steps 64/8, ACK 5 cycles after each WR.
  - Coarse writes: 0, 64, …, 960.
  - Fine pass spans 256..384.
  - Final VCM_DATA = 296 or 304 per model (nearest fine point), then DONE = 1.
- Flat sharpness (all equal) → final VCM_DATA = 0 (tie keeps earliest).
- Best at coarse 0 → fine window clamps to 0..64. Best at 960 → fine window is 896..1023, and 1023 is never exceeded.
- RESET_N low during SETTLE → next cycle VCM_WR = 0, BUSY = 0, FSM in IDLE. START during BUSY → no restart, write sequence unchanged.
